dmem_bus_adapter: RTL and testbench

DMEM_BUS_ADAPTER -- requirements
Module: dmem_bus_adapter

---
 rtl/riscvibe_pkg.sv | 40 ++++
 rtl/dmem_lane_align.sv | 44 ++++
 rtl/dmem_bus_adapter.sv | 149 ++++++++++++++
 tb/tb_dmem_bus_adapter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscvibe_pkg.sv
// Shared types and constants for the RISC-V data-memory path: the bus-adapter
// state encoding, the funct3 load/store width codes and request legality helpers.
package riscvibe_pkg;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_REQ  = 2'd1,
    DMEM_WAIT = 2'd2,
    DMEM_DONE = 2'd3
  } dmem_bus_state_t;

  localparam logic [2:0] MEM_W_B  = 3'b000;
  localparam logic [2:0] MEM_W_H  = 3'b001;
  localparam logic [2:0] MEM_W_W  = 3'b010;
  localparam logic [2:0] MEM_W_BU = 3'b100;
  localparam logic [2:0] MEM_W_HU = 3'b101;

  function automatic logic dmem_width_legal(input logic [2:0] width);
    logic legal;
    legal = 1'b0;
    case (width)
      MEM_W_B, MEM_W_H, MEM_W_W, MEM_W_BU, MEM_W_HU: legal = 1'b1;
      default:                                       legal = 1'b0;
    endcase
    return legal;
  endfunction

  // Only the natural-alignment rule matters here; illegal widths are caught separately.
  function automatic logic dmem_addr_aligned(input logic [2:0] width, input logic [1:0] lsb);
    logic aligned;
    aligned = 1'b1;
    case (width)
      MEM_W_H, MEM_W_HU: aligned = (lsb[0] == 1'b0);
      MEM_W_W:           aligned = (lsb == 2'b00);
      default:           aligned = 1'b1;
    endcase
    return aligned;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data-memory bus: store strobes and data placement,
// and load data extraction with sign or zero extension.
module dmem_lane_align
  import riscvibe_pkg::*;
(
  input  logic [2:0]  width_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] ld_word_i,
  output logic [3:0]  strb_o,
  output logic [31:0] st_data_o,
  output logic [31:0] ld_data_o
);

  logic [4:0]  shamt;
  logic [31:0] ld_shifted;

  assign shamt      = {offset_i, 3'b000};
  assign st_data_o  = st_data_i << shamt;
  assign ld_shifted = ld_word_i >> shamt;

  always_comb begin
    strb_o = 4'b0000;
    case (width_i)
      MEM_W_B, MEM_W_BU: strb_o = 4'b0001 << offset_i;
      MEM_W_H, MEM_W_HU: strb_o = offset_i[1] ? 4'b1100 : 4'b0011;
      MEM_W_W:           strb_o = 4'b1111;
      default:           strb_o = 4'b0000;
    endcase
  end

  always_comb begin
    ld_data_o = 32'h0;
    case (width_i)
      MEM_W_B:  ld_data_o = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      MEM_W_H:  ld_data_o = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      MEM_W_W:  ld_data_o = ld_shifted;
      MEM_W_BU: ld_data_o = {24'h0, ld_shifted[7:0]};
      MEM_W_HU: ld_data_o = {16'h0, ld_shifted[15:0]};
      default:  ld_data_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/dmem_bus_adapter.sv
// Data-memory bus adapter: turns MEM-stage loads/stores into single word-aligned
// bus transactions, stalls the pipeline meanwhile and bounds each access with a timeout.
module dmem_bus_adapter
  import riscvibe_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req_valid,
  input  logic        cpu_req_write,
  input  logic [2:0]  cpu_req_width,
  input  logic [31:0] cpu_req_addr,
  input  logic [31:0] cpu_req_wdata,
  output logic        cpu_stall,
  output logic        cpu_rsp_valid,
  output logic [31:0] cpu_rsp_rdata,
  output logic        cpu_rsp_err,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_req_write,
  output logic [31:0] bus_req_addr,
  output logic [31:0] bus_req_wdata,
  output logic [3:0]  bus_req_strb,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rsp_rdata,
  input  logic        bus_rsp_err
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  dmem_bus_state_t  state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             write_q;
  logic [2:0]       width_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic             bus_req_valid_q;
  logic             rsp_valid_q;
  logic             rsp_err_q;
  logic [31:0]      rsp_rdata_q;

  logic             req_legal;
  logic             timeout_hit;
  logic [31:0]      ld_data;
  logic [31:0]      rsp_rdata_d;

  assign req_legal   = dmem_width_legal(cpu_req_width) &&
                       dmem_addr_aligned(cpu_req_width, cpu_req_addr[1:0]);
  assign timeout_hit = (cnt_q == CNT_LAST);
  assign rsp_rdata_d = (bus_rsp_err || write_q) ? 32'h0 : ld_data;

  dmem_lane_align u_lane_align (
    .width_i   (width_q),
    .offset_i  (addr_q[1:0]),
    .st_data_i (wdata_q),
    .ld_word_i (bus_rsp_rdata),
    .strb_o    (bus_req_strb),
    .st_data_o (bus_req_wdata),
    .ld_data_o (ld_data)
  );

  // The request is latched on acceptance so the bus fields stay stable while the CPU side moves on.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= DMEM_IDLE;
      cnt_q           <= '0;
      write_q         <= 1'b0;
      width_q         <= MEM_W_B;
      addr_q          <= 32'h0;
      wdata_q         <= 32'h0;
      bus_req_valid_q <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_err_q       <= 1'b0;
      rsp_rdata_q     <= 32'h0;
    end else begin
      case (state_q)
        DMEM_IDLE: begin
          if (cpu_req_valid) begin
            write_q <= cpu_req_write;
            width_q <= cpu_req_width;
            addr_q  <= cpu_req_addr;
            wdata_q <= cpu_req_wdata;
            cnt_q   <= '0;
            if (req_legal) begin
              state_q         <= DMEM_REQ;
              bus_req_valid_q <= 1'b1;
            end else begin
              state_q     <= DMEM_DONE;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= 32'h0;
            end
          end
        end
        DMEM_REQ: begin
          cnt_q <= cnt_q + 1'b1;
          if (timeout_hit) begin
            state_q         <= DMEM_DONE;
            bus_req_valid_q <= 1'b0;
            rsp_valid_q     <= 1'b1;
            rsp_err_q       <= 1'b1;
            rsp_rdata_q     <= 32'h0;
          end else if (bus_req_ready) begin
            state_q         <= DMEM_WAIT;
            bus_req_valid_q <= 1'b0;
          end
        end
        DMEM_WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          // A response arriving on the timeout cycle still counts as a real completion.
          if (bus_rsp_valid) begin
            state_q     <= DMEM_DONE;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= bus_rsp_err;
            rsp_rdata_q <= rsp_rdata_d;
          end else if (timeout_hit) begin
            state_q     <= DMEM_DONE;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= 32'h0;
          end
        end
        DMEM_DONE: begin
          state_q     <= DMEM_IDLE;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= 32'h0;
        end
        default: begin
          state_q         <= DMEM_IDLE;
          bus_req_valid_q <= 1'b0;
          rsp_valid_q     <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_stall     = (state_q == DMEM_REQ) || (state_q == DMEM_WAIT) ||
                         ((state_q == DMEM_IDLE) && cpu_req_valid);
  assign cpu_rsp_valid = rsp_valid_q;
  assign cpu_rsp_err   = rsp_err_q;
  assign cpu_rsp_rdata = rsp_rdata_q;
  assign bus_req_valid = bus_req_valid_q;
  assign bus_req_write = write_q;
  assign bus_req_addr  = {addr_q[31:2], 2'b00};

endmodule

// File: tb/tb_dmem_bus_adapter.sv
// Self-checking bench for dmem_bus_adapter: directed vector table, randomized
// transactions against a behavioural model, and reset/retire corner sequences.
module tb_dmem_bus_adapter;

  localparam int T = 8;

  typedef struct {
    logic        write;
    logic [2:0]  width;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        berr;
    int          rdyD;
    int          rspD;
    bit          expBus;
    int          expBusCycles;
    logic [3:0]  expStrb;
    logic [31:0] expBaddr;
    logic [31:0] expBwdata;
    logic [31:0] expRd;
    logic        expErr;
    int          expLat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req_valid;
  logic        cpu_req_write;
  logic [2:0]  cpu_req_width;
  logic [31:0] cpu_req_addr;
  logic [31:0] cpu_req_wdata;
  logic        cpu_stall;
  logic        cpu_rsp_valid;
  logic [31:0] cpu_rsp_rdata;
  logic        cpu_rsp_err;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic        bus_req_write;
  logic [31:0] bus_req_addr;
  logic [31:0] bus_req_wdata;
  logic [3:0]  bus_req_strb;
  logic        bus_rsp_valid;
  logic [31:0] bus_rsp_rdata;
  logic        bus_rsp_err;

  int totalChecks = 0;
  int passChecks  = 0;
  vec_t vecs[16];

  always #5 clk = ~clk;

  dmem_bus_adapter #(.TIMEOUT_CYCLES(T)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cpu_req_valid (cpu_req_valid),
    .cpu_req_write (cpu_req_write),
    .cpu_req_width (cpu_req_width),
    .cpu_req_addr  (cpu_req_addr),
    .cpu_req_wdata (cpu_req_wdata),
    .cpu_stall     (cpu_stall),
    .cpu_rsp_valid (cpu_rsp_valid),
    .cpu_rsp_rdata (cpu_rsp_rdata),
    .cpu_rsp_err   (cpu_rsp_err),
    .bus_req_valid (bus_req_valid),
    .bus_req_ready (bus_req_ready),
    .bus_req_write (bus_req_write),
    .bus_req_addr  (bus_req_addr),
    .bus_req_wdata (bus_req_wdata),
    .bus_req_strb  (bus_req_strb),
    .bus_rsp_valid (bus_rsp_valid),
    .bus_rsp_rdata (bus_rsp_rdata),
    .bus_rsp_err   (bus_rsp_err)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalChecks++;
    if (act === exp) passChecks++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: access size, natural alignment and cycle budget from plain arithmetic.
  task automatic refModel(input vec_t vin, output vec_t vout);
    int size, off, rspCycle;
    longint v, full;
    vout = vin;
    case (vin.width)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    off = int'(vin.addr % 4);
    vout.expStrb = 4'h0; vout.expBaddr = 32'h0; vout.expBwdata = 32'h0; vout.expRd = 32'h0;
    if (size == 0 || (vin.addr % size) != 0) begin
      vout.expBus = 1'b0; vout.expBusCycles = 0; vout.expErr = 1'b1; vout.expLat = 1;
    end else begin
      vout.expBus    = 1'b1;
      vout.expBaddr  = vin.addr - 32'(off);
      vout.expStrb   = 4'(((1 << size) - 1) * (1 << off));
      vout.expBwdata = 32'(longint'(vin.wdata) * (longint'(1) << (8 * off)));
      rspCycle = 2 + vin.rdyD + vin.rspD;
      if (vin.rdyD >= T) begin
        vout.expBusCycles = T; vout.expLat = T + 1; vout.expErr = 1'b1;
      end else begin
        vout.expBusCycles = vin.rdyD + 1;
        if (rspCycle <= T) begin
          vout.expLat = rspCycle + 1;
          vout.expErr = vin.berr;
          full = longint'(1) << (8 * size);
          v = (longint'(vin.rdata) / (longint'(1) << (8 * off))) % full;
          if ((vin.width == 3'd0 || vin.width == 3'd1) && v >= full / 2) v = v - full;
          if (!vin.berr && !vin.write) vout.expRd = 32'(v);
        end else begin
          vout.expLat = T + 1; vout.expErr = 1'b1;
        end
      end
    end
  endtask

  // Plays CPU and bus for one access, then compares everything observed with the record.
  task automatic applyStimulus(input vec_t v, input string tag);
    int lat, busCyc, waitIdx;
    bit hs, done, stallOk, stableOk;
    logic [31:0] capAddr, capWdata, gotRd;
    logic [3:0]  capStrb;
    logic        capWrite, gotErr;
    lat = 0; busCyc = 0; waitIdx = 0; hs = 0; done = 0; stallOk = 1; stableOk = 1;
    capAddr = 0; capWdata = 0; capStrb = 0; capWrite = 0; gotRd = 0; gotErr = 0;
    cpu_req_valid = 1'b1;
    cpu_req_write = v.write;
    cpu_req_width = v.width;
    cpu_req_addr  = v.addr;
    cpu_req_wdata = v.wdata;
    #1;
    if (cpu_stall !== 1'b1) stallOk = 0;
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      tick();
      bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_rdata = 32'h0; bus_rsp_err = 1'b0;
      if (cpu_rsp_valid === 1'b1) begin
        done = 1; lat = cyc; gotErr = cpu_rsp_err; gotRd = cpu_rsp_rdata;
        cpu_req_valid = 1'b0;
        if (cpu_stall !== 1'b0) stallOk = 0;
      end else begin
        if (cpu_stall !== 1'b1) stallOk = 0;
        if (bus_req_valid === 1'b1) begin
          if (busCyc == 0) begin
            capAddr = bus_req_addr; capWdata = bus_req_wdata;
            capStrb = bus_req_strb; capWrite = bus_req_write;
          end else if (capAddr !== bus_req_addr || capWdata !== bus_req_wdata ||
                       capStrb !== bus_req_strb || capWrite !== bus_req_write) begin
            stableOk = 0;
          end
          if (busCyc == v.rdyD) begin
            bus_req_ready = 1'b1; hs = 1;
          end
          busCyc++;
        end else if (hs) begin
          if (waitIdx == v.rspD) begin
            bus_rsp_valid = 1'b1; bus_rsp_rdata = v.rdata; bus_rsp_err = v.berr;
          end
          waitIdx++;
        end
      end
    end
    cpu_req_valid = 1'b0;
    checkOutput({tag, ".latency"}, 32'(lat), 32'(v.expLat));
    checkOutput({tag, ".err"}, 32'(gotErr), 32'(v.expErr));
    checkOutput({tag, ".rdata"}, gotRd, v.expRd);
    checkOutput({tag, ".busCycles"}, 32'(busCyc), 32'(v.expBusCycles));
    checkOutput({tag, ".stall"}, 32'(stallOk), 32'd1);
    if (v.expBus) begin
      checkOutput({tag, ".busAddr"}, capAddr, v.expBaddr);
      checkOutput({tag, ".busWrite"}, 32'(capWrite), 32'(v.write));
      checkOutput({tag, ".stable"}, 32'(stableOk), 32'd1);
      if (v.write) begin
        checkOutput({tag, ".strb"}, 32'(capStrb), 32'(v.expStrb));
        checkOutput({tag, ".busWdata"}, capWdata, v.expBwdata);
      end
    end
    tick();
    checkOutput({tag, ".pulseEnd"}, 32'({cpu_rsp_valid, bus_req_valid, cpu_stall}), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t r, m;
    bit flag;
    rst_n = 1'b0; cpu_req_valid = 1'b0; cpu_req_write = 1'b0; cpu_req_width = 3'd0;
    cpu_req_addr = 32'h0; cpu_req_wdata = 32'h0; bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0; bus_rsp_rdata = 32'h0; bus_rsp_err = 1'b0;

    //            wr    wid     addr        wdata         rdata        berr rdy rsp bus cyc strb    baddr       bwdata        rd            err  lat
    vecs[0]  = '{1'b0, 3'b000, 32'h103, 32'h0,        32'h80FF0000, 1'b0, 0, 0, 1'b1, 1, 4'h0,    32'h100, 32'h0,        32'hFFFFFF80, 1'b0, 3};
    vecs[1]  = '{1'b1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0,        1'b0, 0, 0, 1'b1, 1, 4'b1100, 32'h200, 32'hABCD0000, 32'h0,        1'b0, 3};
    vecs[2]  = '{1'b0, 3'b010, 32'h006, 32'h0,        32'h0,        1'b0, 0, 0, 1'b0, 0, 4'h0,    32'h0,   32'h0,        32'h0,        1'b1, 1};
    vecs[3]  = '{1'b0, 3'b101, 32'h002, 32'h0,        32'h80011234, 1'b0, 2, 1, 1'b1, 3, 4'h0,    32'h0,   32'h0,        32'h00008001, 1'b0, 6};
    vecs[4]  = '{1'b0, 3'b001, 32'h002, 32'h0,        32'h80011234, 1'b0, 0, 0, 1'b1, 1, 4'h0,    32'h0,   32'h0,        32'hFFFF8001, 1'b0, 3};
    vecs[5]  = '{1'b1, 3'b000, 32'h001, 32'h000000A5, 32'h0,        1'b0, 1, 0, 1'b1, 2, 4'b0010, 32'h0,   32'h0000A500, 32'h0,        1'b0, 4};
    vecs[6]  = '{1'b1, 3'b010, 32'h010, 32'hDEADBEEF, 32'h0,        1'b0, 0, 2, 1'b1, 1, 4'b1111, 32'h010, 32'hDEADBEEF, 32'h0,        1'b0, 5};
    vecs[7]  = '{1'b0, 3'b011, 32'h000, 32'h0,        32'h0,        1'b0, 0, 0, 1'b0, 0, 4'h0,    32'h0,   32'h0,        32'h0,        1'b1, 1};
    vecs[8]  = '{1'b0, 3'b010, 32'h020, 32'h0,        32'h12345678, 1'b1, 0, 0, 1'b1, 1, 4'h0,    32'h020, 32'h0,        32'h0,        1'b1, 3};
    vecs[9]  = '{1'b0, 3'b100, 32'h001, 32'h0,        32'h0000F000, 1'b0, 0, 0, 1'b1, 1, 4'h0,    32'h0,   32'h0,        32'h000000F0, 1'b0, 3};
    vecs[10] = '{1'b0, 3'b010, 32'h030, 32'h0,        32'h0,        1'b0, 99, 0, 1'b1, 8, 4'h0,   32'h030, 32'h0,        32'h0,        1'b1, 9};
    vecs[11] = '{1'b0, 3'b010, 32'h034, 32'h0,        32'h11223344, 1'b0, 0, 6, 1'b1, 1, 4'h0,    32'h034, 32'h0,        32'h11223344, 1'b0, 9};
    vecs[12] = '{1'b0, 3'b010, 32'h038, 32'h0,        32'h55667788, 1'b0, 0, 7, 1'b1, 1, 4'h0,    32'h038, 32'h0,        32'h0,        1'b1, 9};
    vecs[13] = '{1'b1, 3'b001, 32'h201, 32'h00001234, 32'h0,        1'b0, 0, 0, 1'b0, 0, 4'h0,    32'h0,   32'h0,        32'h0,        1'b1, 1};
    vecs[14] = '{1'b1, 3'b010, 32'h044, 32'hCAFEBABE, 32'hFFFFFFFF, 1'b1, 1, 1, 1'b1, 2, 4'b1111, 32'h044, 32'hCAFEBABE, 32'h0,        1'b1, 5};
    vecs[15] = '{1'b1, 3'b111, 32'h048, 32'h0,        32'h0,        1'b0, 0, 0, 1'b0, 0, 4'h0,    32'h0,   32'h0,        32'h0,        1'b1, 1};

    repeat (3) tick();
    checkOutput("reset.outputs",
                32'({bus_req_valid, cpu_rsp_valid, cpu_rsp_err, cpu_stall}), 32'd0);
    checkOutput("reset.rdata", cpu_rsp_rdata, 32'h0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      r = vecs[0];
      r.write = 1'($urandom_range(0, 1));
      r.width = 3'($urandom_range(0, 7));
      r.addr  = $urandom & 32'h0000FFFF;
      r.wdata = $urandom;
      r.rdata = $urandom;
      r.berr  = ($urandom_range(0, 5) == 0);
      r.rdyD  = int'($urandom_range(0, 3));
      r.rspD  = int'($urandom_range(0, 7));
      refModel(r, m);
      applyStimulus(m, $sformatf("rand%0d", i));
    end

    // A request still held high during the retiring cycle must not start a new access.
    cpu_req_valid = 1'b1; cpu_req_write = 1'b0; cpu_req_width = 3'b010;
    cpu_req_addr = 32'h50; cpu_req_wdata = 32'h0;
    tick(); bus_req_ready = 1'b1;
    tick(); bus_req_ready = 1'b0; bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'hCAFEF00D;
    tick(); bus_rsp_valid = 1'b0; bus_rsp_rdata = 32'h0;
    checkOutput("retire.rspValid", 32'(cpu_rsp_valid), 32'd1);
    checkOutput("retire.rdata", cpu_rsp_rdata, 32'hCAFEF00D);
    tick();
    checkOutput("retire.ignored", 32'({cpu_rsp_valid, bus_req_valid}), 32'd0);
    checkOutput("retire.idleStall", 32'(cpu_stall), 32'd1);
    cpu_req_valid = 1'b0;
    tick();
    checkOutput("retire.noBus", 32'(bus_req_valid), 32'd0);

    // Reset while waiting for the bus response, then a late response.
    cpu_req_valid = 1'b1; cpu_req_addr = 32'h40;
    tick();
    checkOutput("rstWait.reqValid", 32'(bus_req_valid), 32'd1);
    bus_req_ready = 1'b1;
    tick(); bus_req_ready = 1'b0;
    checkOutput("rstWait.inWait", 32'({bus_req_valid, cpu_stall}), 32'b01);
    rst_n = 1'b0; cpu_req_valid = 1'b0;
    tick();
    checkOutput("rstWait.outputs",
                32'({bus_req_valid, cpu_rsp_valid, cpu_rsp_err, cpu_stall}), 32'd0);
    checkOutput("rstWait.rdata", cpu_rsp_rdata, 32'h0);
    rst_n = 1'b1;
    tick(); bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'h0BADF00D;
    flag = 1;
    for (int k = 0; k < 4; k++) begin
      tick(); bus_rsp_valid = 1'b0; bus_rsp_rdata = 32'h0;
      if (cpu_rsp_valid !== 1'b0 || bus_req_valid !== 1'b0 || cpu_stall !== 1'b0) flag = 0;
    end
    checkOutput("rstWait.lateRspIgnored", 32'(flag), 32'd1);

    // Reset while the request is still being offered.
    cpu_req_valid = 1'b1; cpu_req_write = 1'b1; cpu_req_addr = 32'h60; cpu_req_wdata = 32'h1;
    tick();
    checkOutput("rstReq.reqValid", 32'(bus_req_valid), 32'd1);
    rst_n = 1'b0; cpu_req_valid = 1'b0;
    tick();
    checkOutput("rstReq.dropped", 32'(bus_req_valid), 32'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("rstReq.staysIdle", 32'({bus_req_valid, cpu_rsp_valid}), 32'd0);

    applyStimulus(vecs[0], "afterReset");

    $display("%0d/%0d checks passed", passChecks, totalChecks);
    $finish;
  end

endmodule
